// File: rtl/alu_pipe.sv
// Pipelined 74181-style ALU: any even WIDTH, STAGES-deep, valid/ready on both sides.
// Carries an opaque tag and keeps a carry-chain register for multi-word arithmetic.
module alu_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       opcode,
  input  logic             mode,
  input  logic             carry_in,
  input  logic             carry_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             nBo,
  output logic             nGo,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] res;
    logic             co;
    logic             nbo;
    logic             ngo;
    logic             z;
    logic [TAG_W-1:0] tag;
  } stg_t;

  localparam stg_t STG_RST = '{
    v:   1'b0,
    res: '0,
    co:  1'b0,
    nbo: 1'b1,
    ngo: 1'b1,
    z:   1'b0,
    tag: '0
  };

  stg_t           stg_q [STAGES];
  stg_t           stg_d;
  logic           chain_q;
  logic           chain_d;
  logic           stall;
  logic           accept;
  logic           cin;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0] pg;
  logic [WIDTH:0] sum;

  assign stall    = stg_q[STAGES-1].v && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    cin = carry_sel ? chain_q : carry_in;
    p   = operand_a
        | (operand_b & {WIDTH{opcode[0]}})
        | (~operand_b & {WIDTH{opcode[1]}});
    g   = (operand_a & ~operand_b & {WIDTH{opcode[2]}})
        | (operand_a & operand_b & {WIDTH{opcode[3]}});
    pg  = {1'b0, p} + {1'b0, g};
    sum = pg + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    stg_d = STG_RST;
    if (in_valid) begin
      stg_d.v   = 1'b1;
      stg_d.tag = in_tag;
      if (mode) begin
        stg_d.res = ~(p ^ g);
      end else begin
        stg_d.res = sum[WIDTH-1:0];
        stg_d.co  = sum[WIDTH];
        stg_d.nbo = !(!pg[WIDTH] && (pg[WIDTH-1:0] == {WIDTH{1'b1}}));
        stg_d.ngo = !pg[WIDTH];
      end
      stg_d.z = (stg_d.res == '0);
    end
  end

  // chain only tracks accepted arithmetic ops so chained words can issue back-to-back
  assign chain_d = (accept && !mode) ? sum[WIDTH] : chain_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_q[i] <= STG_RST;
      end
      chain_q <= 1'b0;
    end else if (!stall) begin
      stg_q[0] <= stg_d;
      for (int i = 1; i < STAGES; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
      chain_q <= chain_d;
    end
  end

  assign out_valid = stg_q[STAGES-1].v;
  assign result    = stg_q[STAGES-1].res;
  assign carry_out = stg_q[STAGES-1].co;
  assign nBo       = stg_q[STAGES-1].nbo;
  assign nGo       = stg_q[STAGES-1].ngo;
  assign zero      = stg_q[STAGES-1].z;
  assign out_tag   = stg_q[STAGES-1].tag;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: hand-computed expectations queued on issue,
// popped and compared by an independent output monitor.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [3:0]  opcode;
  logic        mode;
  logic        carry_in;
  logic        carry_sel;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry_out;
  logic        nBo;
  logic        nGo;
  logic        zero;
  logic [3:0]  out_tag;

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        nbo;
    logic        ngo;
    logic        z;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  alu_pipe #(.WIDTH(16), .STAGES(2), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .opcode    (opcode),
    .mode      (mode),
    .carry_in  (carry_in),
    .carry_sel (carry_sel),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .nBo       (nBo),
    .nGo       (nGo),
    .zero      (zero),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic co,
                              input logic nbo, input logic ngo,
                              input logic [3:0] t);
    exp_t e;
    e.res = r;
    e.co  = co;
    e.nbo = nbo;
    e.ngo = ngo;
    e.z   = (r == 16'h0);
    e.tag = t;
    return e;
  endfunction

  task automatic issue(input logic m, input logic [3:0] s,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic cs,
                       input logic [3:0] t, input bit push,
                       input exp_t e);
    bit ok = 1'b0;
    mode      = m;
    opcode    = s;
    operand_a = a;
    operand_b = b;
    carry_in  = ci;
    carry_sel = cs;
    in_tag    = t;
    in_valid  = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout tag=%0d got=not_accepted exp=accepted", t);
    end else if (push) begin
      q.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got tag=%0d res=%h exp=none",
                 out_tag, result);
      end else begin
        e = q.pop_front();
        if ({result, carry_out, nBo, nGo, zero, out_tag} !==
            {e.res, e.co, e.nbo, e.ngo, e.z, e.tag}) begin
          errors++;
          $display("FAIL result_tag%0d got res=%h co=%b nBo=%b nGo=%b z=%b tag=%0d exp res=%h co=%b nBo=%b nGo=%b z=%b tag=%0d",
                   e.tag, result, carry_out, nBo, nGo, zero, out_tag,
                   e.res, e.co, e.nbo, e.ngo, e.z, e.tag);
        end
      end
    end
  end

  task automatic chk_reset_state(input string name);
    chk({name, "_valid"}, 32'(out_valid), 32'h0);
    chk({name, "_ready"}, 32'(in_ready), 32'h1);
    chk({name, "_outs"},
        {7'h0, result, carry_out, nBo, nGo, zero, out_tag},
        {7'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0});
  endtask

  exp_t nul;
  logic [24:0] snap;
  bit   seen;

  initial begin
    nul = mk(16'h0, 1'b0, 1'b1, 1'b1, 4'h0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    operand_a = '0;
    operand_b = '0;
    opcode = '0;
    mode = 1'b0;
    carry_in = 1'b0;
    carry_sel = 1'b0;
    in_tag = '0;
    tick(2);
    chk_reset_state("reset_initial");
    rst_n = 1'b1;
    tick(1);

    out_ready = 1'b0;
    issue(0, 4'd9, 16'hFFFF, 16'h0001, 0, 0, 4'd7, 0, nul);
    issue(1, 4'd6, 16'h1234, 16'h4321, 0, 0, 4'd8, 0, nul);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk_reset_state("reset_midflight");
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("reset_no_output", 32'(out_valid), 32'h0);
    end
    issue(0, 4'd9, 16'h0000, 16'h0000, 0, 1, 4'd9, 1,
          mk(16'h0000, 0, 1, 1, 4'd9));
    tick(4);

    issue(0, 4'd9, 16'hFFFF, 16'h0001, 0, 0, 4'd3, 1,
          mk(16'h0000, 1, 1, 0, 4'd3));
    chk("latency_not_early", 32'(out_valid), 32'h0);
    tick(1);
    chk("latency_valid", {27'h0, out_valid, out_tag}, {27'h0, 1'b1, 4'd3});
    issue(0, 4'd9, 16'hFFFF, 16'h0000, 0, 0, 4'd4, 1,
          mk(16'hFFFF, 0, 0, 1, 4'd4));
    issue(0, 4'd15, 16'h0000, 16'h1234, 0, 0, 4'd5, 1,
          mk(16'hFFFF, 0, 0, 1, 4'd5));

    issue(0, 4'd9, 16'hFFFF, 16'h0001, 0, 0, 4'd6, 1,
          mk(16'h0000, 1, 1, 0, 4'd6));
    issue(0, 4'd9, 16'h0000, 16'h0000, 0, 1, 4'd7, 1,
          mk(16'h0001, 0, 1, 1, 4'd7));

    issue(0, 4'd6, 16'h0003, 16'h0005, 1, 0, 4'd8, 1,
          mk(16'hFFFE, 0, 1, 1, 4'd8));
    issue(0, 4'd6, 16'h0005, 16'h0003, 1, 0, 4'd9, 1,
          mk(16'h0002, 1, 1, 0, 4'd9));

    issue(1, 4'd6, 16'h00FF, 16'h0F0F, 0, 0, 4'd10, 1,
          mk(16'h0FF0, 0, 1, 1, 4'd10));
    issue(1, 4'd11, 16'h00FF, 16'h0F0F, 0, 0, 4'd11, 1,
          mk(16'h000F, 0, 1, 1, 4'd11));
    issue(1, 4'd14, 16'h00FF, 16'h0F0F, 0, 0, 4'd12, 1,
          mk(16'h0FFF, 0, 1, 1, 4'd12));
    issue(1, 4'd0, 16'h00FF, 16'h0F0F, 0, 0, 4'd13, 1,
          mk(16'hFF00, 0, 1, 1, 4'd13));
    issue(1, 4'd11, 16'h00FF, 16'hFF00, 1, 0, 4'd14, 1,
          mk(16'h0000, 0, 1, 1, 4'd14));
    issue(0, 4'd9, 16'h0000, 16'h0000, 0, 1, 4'd15, 1,
          mk(16'h0001, 0, 1, 1, 4'd15));
    tick(4);

    out_ready = 1'b0;
    fork
      begin
        issue(0, 4'd9, 16'h0001, 16'h0001, 0, 0, 4'd1, 1,
              mk(16'h0002, 0, 1, 1, 4'd1));
        issue(0, 4'd9, 16'h0002, 16'h0003, 0, 0, 4'd2, 1,
              mk(16'h0005, 0, 1, 1, 4'd2));
        issue(0, 4'd9, 16'h0010, 16'h0020, 0, 0, 4'd3, 1,
              mk(16'h0030, 0, 1, 1, 4'd3));
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
          @(negedge clk);
          seen = out_valid;
        end
        chk("stall_valid_seen", 32'(seen), 32'h1);
        snap = {out_valid, result, carry_out, nBo, nGo, zero, out_tag};
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'h0);
          chk("stall_stable",
              {7'h0, out_valid, result, carry_out, nBo, nGo, zero, out_tag},
              {7'h0, snap});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join

    for (int k = 0; k < 20 && q.size() != 0; k++) tick(1);
    tick(2);
    chk("drain_empty", 32'(q.size()), 32'h0);
    chk("idle_after_drain", 32'(out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
